// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx is synchronized, the start bit is confirmed at mid-bit,
// and each later bit is sampled one bit period after the previous sample.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic          rx_d_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= (state_q != IDLE);
      case (state_q)
        // Only a 1->0 transition starts a frame, so a held-low line never retriggers.
        IDLE: begin
          if (rx_d_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              idx_q   <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a directed rx waveform is built up front, a frame-level model
// derives the expected outputs per cycle, and one process compares every cycle.
module tb_uart_rx;

  localparam int C = 4;
  localparam int N = 450;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic       line_v [N];
  logic       rst_v  [N];
  logic       s_m    [N];
  logic       d_m    [N];
  logic [7:0] exp_data  [N];
  logic       exp_valid [N];
  logic       exp_ferr  [N];
  logic       exp_busy  [N];

  int pos;
  int checks;
  int failures;
  int s_a5;
  int g_idx;
  int rel_edge;
  int nferr;
  logic [7:0] data_rel;
  logic [7:0] data_e1;
  logic [2:0] flags_e1;
  logic       busy_g;
  logic [7:0] vq[$];
  int         vedge[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int e);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, e, act, req);
    end
  endtask

  task automatic put(input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      if (pos < N) begin
        line_v[pos] = b;
        rst_v[pos]  = r;
        pos++;
      end
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic stop);
    put(1'b0, 1'b0, C);
    for (int i = 0; i < 8; i++) put(b[i], 1'b0, C);
    put(stop, 1'b0, C);
  endtask

  // Edge e sees rx=line_v[e-1]; rx_s after edge e therefore reflects line_v[e-2].
  task automatic build_model();
    bit         in_frame;
    int         t0;
    int         rel;
    int         n;
    logic [7:0] sh;
    logic [7:0] dq;
    in_frame = 0;
    t0 = 0;
    sh = 8'h00;
    dq = 8'h00;
    s_m[0] = 1'b1;
    d_m[0] = 1'b1;
    exp_data[0] = 8'h00; exp_valid[0] = 1'b0; exp_ferr[0] = 1'b0; exp_busy[0] = 1'b0;
    for (int e = 1; e < N; e++) begin
      if (rst_v[e-1] || (e >= 2 && rst_v[e-2]) || e < 2) s_m[e] = 1'b1;
      else s_m[e] = line_v[e-2];
      d_m[e] = rst_v[e-1] ? 1'b1 : s_m[e-1];
    end
    for (int e = 1; e < N; e++) begin
      exp_valid[e] = 1'b0;
      exp_ferr[e]  = 1'b0;
      if (rst_v[e-1]) begin
        in_frame    = 0;
        dq          = 8'h00;
        exp_busy[e] = 1'b0;
        exp_data[e] = 8'h00;
        continue;
      end
      exp_busy[e] = in_frame;
      if (!in_frame) begin
        if (!s_m[e-1] && d_m[e-1]) begin
          in_frame = 1;
          t0 = e;
        end
      end else begin
        rel = e - t0;
        if (rel == C / 2) begin
          if (s_m[e-1]) in_frame = 0;
        end else if (rel > C / 2 && ((rel - C / 2) % C) == 0) begin
          n = (rel - C / 2) / C;
          if (n <= 8) begin
            sh[n-1] = s_m[e-1];
          end else begin
            if (s_m[e-1]) begin
              dq = sh;
              exp_valid[e] = 1'b1;
            end else begin
              exp_ferr[e] = 1'b1;
            end
            in_frame = 0;
          end
        end
      end
      exp_data[e] = dq;
    end
  endtask

  initial begin
    int mv;
    int mf;
    checks = 0;
    failures = 0;
    nferr = 0;
    pos = 0;
    rx = 1'b1;
    reset = 1'b1;
    data_rel = 8'hxx;
    data_e1 = 8'hxx;
    flags_e1 = 3'bxxx;
    busy_g = 1'bx;

    put(1'b1, 1'b1, 3);
    put(1'b1, 1'b0, 10);
    s_a5 = pos;
    frame(8'hA5, 1'b1);
    put(1'b1, 1'b0, 8);
    frame(8'h3C, 1'b0);
    put(1'b0, 1'b0, 20 * C);
    put(1'b1, 1'b0, 8);
    g_idx = pos;
    put(1'b0, 1'b0, 1);
    put(1'b1, 1'b0, 12);
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    put(1'b1, 1'b0, 8);
    put(1'b0, 1'b0, C);
    for (int i = 0; i < 4; i++) put(mv_bit(8'h5A, i), 1'b0, C);
    put(1'b1, 1'b0, 2);
    put(1'b1, 1'b1, 3);
    rel_edge = pos + 1;
    put(1'b1, 1'b0, 6);
    frame(8'h81, 1'b1);
    put(1'b1, 1'b0, N - pos);

    build_model();

    fork
      begin
        for (int k = 0; k < N; k++) begin
          @(posedge clk);
          #1;
          rx    = line_v[k];
          reset = rst_v[k];
        end
      end
      begin
        for (int e = 0; e < N; e++) begin
          @(posedge clk);
          @(negedge clk);
          if (e >= 1) begin
            chk("valid", {31'b0, valid}, {31'b0, exp_valid[e]}, e);
            chk("frame_err", {31'b0, frame_err}, {31'b0, exp_ferr[e]}, e);
            chk("busy", {31'b0, busy}, {31'b0, exp_busy[e]}, e);
            chk("data", {24'b0, data}, {24'b0, exp_data[e]}, e);
            if (valid === 1'b1) begin
              vq.push_back(data);
              vedge.push_back(e);
            end
            if (frame_err === 1'b1) nferr++;
            if (e == 1) begin
              data_e1  = data;
              flags_e1 = {valid, frame_err, busy};
            end
            if (e == rel_edge) data_rel = data;
            if (e == g_idx + 3 + C / 2 + 3) busy_g = busy;
          end
        end
      end
    join

    chk("reset_data", {24'b0, data_e1}, 32'h0, 1);
    chk("reset_flags", {29'b0, flags_e1}, 32'h0, 1);
    chk("valid_count", vq.size(), 4, N);
    chk("byte0", {24'b0, (vq.size() > 0) ? vq[0] : 8'hxx}, 32'hA5, N);
    chk("byte1", {24'b0, (vq.size() > 1) ? vq[1] : 8'hxx}, 32'h00, N);
    chk("byte2", {24'b0, (vq.size() > 2) ? vq[2] : 8'hxx}, 32'hFF, N);
    chk("byte3", {24'b0, (vq.size() > 3) ? vq[3] : 8'hxx}, 32'h81, N);
    chk("a5_latency", (vedge.size() > 0) ? vedge[0] : -1, s_a5 + 41, N);
    chk("ferr_count", nferr, 1, N);
    chk("data_after_abort", {24'b0, data_rel}, 32'h0, rel_edge);
    chk("glitch_busy_low", {31'b0, busy_g}, 32'h0, g_idx);
    mv = 0;
    mf = 0;
    for (int e = 0; e < N; e++) begin
      if (exp_valid[e]) mv++;
      if (exp_ferr[e]) mf++;
    end
    chk("model_valid_count", mv, 4, N);
    chk("model_ferr_count", mf, 1, N);
    chk("model_final_data", {24'b0, exp_data[N-1]}, 32'h81, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic mv_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
